// File: rtl/vrf_banked_seq.sv
// Banked vector register file: LANES banks, sequential A/B/C operand fetch, byte-enabled writes, v0 mask mirror.
// Latency: accept at edge 0, operand N captured on edge N, rd_done_o high in the following cycle.
// Backpressure: rd_ready_o low while a fetch is in flight; requests then are dropped. Writes always accepted.
// Optional feature macro: VRF_WR_BYPASS_EN (write-through of a colliding write into the captured operand).
module vrf_banked_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_NUM    = 32,
   parameter int LANES      = 4,
   localparam int ADDR_B    = $clog2(REG_NUM),
   localparam int ELEM_B    = $clog2(LANES),
   localparam int BE_B      = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rd_valid_i,
   output logic                  rd_ready_o,
   input  logic [1:0]            rd_nops_i,
   input  logic [ADDR_B-1:0]     a_addr_i,
   input  logic [ADDR_B-1:0]     b_addr_i,
   input  logic [ADDR_B-1:0]     c_addr_i,
   output logic                  rd_done_o,
   input  logic [ELEM_B-1:0]     rd_elem_i,
   output logic [DATA_WIDTH-1:0] a_rdata_o,
   output logic [DATA_WIDTH-1:0] b_rdata_o,
   output logic [DATA_WIDTH-1:0] c_rdata_o,
   input  logic                  wr_en_i,
   input  logic [ADDR_B-1:0]     wr_addr_i,
   input  logic [ELEM_B-1:0]     wr_elem_i,
   input  logic [BE_B-1:0]       wr_be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  mask_en_i,
   output logic [DATA_WIDTH-1:0] mask_rdata_o
);

   typedef enum logic [1:0] {IDLE, RD_A, RD_B, RD_C} state_t;
   typedef logic [LANES-1:0][DATA_WIDTH-1:0] vreg_t;

   state_t              state_q, state_d;
   logic                done_q, done_d;
   logic [1:0]          nops_q, nops_d;
   logic [ADDR_B-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;

   vreg_t               mem_q [REG_NUM];
   vreg_t               mem_d [REG_NUM];
   vreg_t               a_reg_q, a_reg_d, b_reg_q, b_reg_d, c_reg_q, c_reg_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] wr_merged;
   logic [ADDR_B-1:0]   cap_addr;
   vreg_t               cap_row;

   // Byte-merge the incoming write with the element it lands on.
   always_comb begin
      wr_merged = mem_q[wr_addr_i][wr_elem_i];
      for (int k = 0; k < BE_B; k++) begin
         if (wr_be_i[k]) wr_merged[k*8 +: 8] = wdata_i[k*8 +: 8];
      end
   end

   // Next storage and mask contents; a write to v0 lane 0 is mirrored into the mask.
   always_comb begin
      for (int r = 0; r < REG_NUM; r++) mem_d[r] = mem_q[r];
      mask_d = mask_q;
      if (wr_en_i) begin
         mem_d[wr_addr_i][wr_elem_i] = wr_merged;
         if (wr_addr_i == '0 && wr_elem_i == '0) mask_d = wr_merged;
      end
   end

   // Select the row captured this cycle; with bypass a same-edge write is seen by the capture.
   always_comb begin
      case (state_q)
         RD_B:    cap_addr = b_addr_q;
         RD_C:    cap_addr = c_addr_q;
         default: cap_addr = a_addr_q;
      endcase
`ifdef VRF_WR_BYPASS_EN
      cap_row = mem_d[cap_addr];
`else
      cap_row = mem_q[cap_addr];
`endif
   end

   // Fetch sequencing: next state, done pulse, request latching and operand capture.
   always_comb begin
      state_d  = state_q;
      done_d   = 1'b0;
      nops_d   = nops_q;
      a_addr_d = a_addr_q;
      b_addr_d = b_addr_q;
      c_addr_d = c_addr_q;
      a_reg_d  = a_reg_q;
      b_reg_d  = b_reg_q;
      c_reg_d  = c_reg_q;
      case (state_q)
         IDLE: begin
            if (rd_valid_i) begin
               state_d  = RD_A;
               nops_d   = (rd_nops_i == 2'd0) ? 2'd1 : rd_nops_i;
               a_addr_d = a_addr_i;
               b_addr_d = b_addr_i;
               c_addr_d = c_addr_i;
            end
         end
         RD_A: begin
            a_reg_d = cap_row;
            if (nops_q >= 2'd2) state_d = RD_B;
            else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         RD_B: begin
            b_reg_d = cap_row;
            if (nops_q == 2'd3) state_d = RD_C;
            else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            c_reg_d = cap_row;
            state_d = IDLE;
            done_d  = 1'b1;
         end
      endcase
   end

   // FSM and latched request; registered done pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         done_q   <= 1'b0;
         nops_q   <= 2'd1;
         a_addr_q <= '0;
         b_addr_q <= '0;
         c_addr_q <= '0;
      end else begin
         state_q  <= state_d;
         done_q   <= done_d;
         nops_q   <= nops_d;
         a_addr_q <= a_addr_d;
         b_addr_q <= b_addr_d;
         c_addr_q <= c_addr_d;
      end
   end

   // Register file banks, operand registers and mask mirror.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < REG_NUM; r++) mem_q[r] <= '0;
         a_reg_q <= '0;
         b_reg_q <= '0;
         c_reg_q <= '0;
         mask_q  <= '0;
      end else begin
         for (int r = 0; r < REG_NUM; r++) mem_q[r] <= mem_d[r];
         a_reg_q <= a_reg_d;
         b_reg_q <= b_reg_d;
         c_reg_q <= c_reg_d;
         mask_q  <= mask_d;
      end
   end

   assign rd_ready_o   = (state_q == IDLE);
   assign rd_done_o    = done_q;
   assign a_rdata_o    = a_reg_q[rd_elem_i];
   assign b_rdata_o    = b_reg_q[rd_elem_i];
   assign c_rdata_o    = c_reg_q[rd_elem_i];
   assign mask_rdata_o = mask_en_i ? mask_q : '0;

endmodule

// File: tb/tb_vrf_banked_seq.sv
// Directed bench for vrf_banked_seq: fetch results checked against a bench-side register model via a scoreboard queue.
module tb_vrf_banked_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_valid;
   logic        rd_ready;
   logic [1:0]  rd_nops;
   logic [4:0]  a_addr, b_addr, c_addr;
   logic        rd_done;
   logic [1:0]  rd_elem;
   logic [31:0] a_rdata, b_rdata, c_rdata;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [1:0]  wr_elem;
   logic [3:0]  wr_be;
   logic [31:0] wdata;
   logic        mask_en;
   logic [31:0] mask_rdata;

   always #5 clk = ~clk;

   vrf_banked_seq dut (
      .clk_i(clk), .rst_i(rst),
      .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_nops_i(rd_nops),
      .a_addr_i(a_addr), .b_addr_i(b_addr), .c_addr_i(c_addr),
      .rd_done_o(rd_done), .rd_elem_i(rd_elem),
      .a_rdata_o(a_rdata), .b_rdata_o(b_rdata), .c_rdata_o(c_rdata),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_elem_i(wr_elem), .wr_be_i(wr_be), .wdata_i(wdata),
      .mask_en_i(mask_en), .mask_rdata_o(mask_rdata)
   );

   typedef struct packed {
      logic [3:0][31:0] a;
      logic [3:0][31:0] b;
      logic [3:0][31:0] c;
   } opnd_t;

   logic [3:0][31:0] model [32];
   opnd_t            exp_prev;
   opnd_t            sb [$];
   int               errors = 0;
   int               checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = nw[k*8 +: 8];
      return r;
   endfunction

   task automatic do_write(input int ra, input int el, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = ra[4:0]; wr_elem = el[1:0]; wdata = d; wr_be = be;
      model[ra][el] = merge(model[ra][el], d, be);
      @(negedge clk);
      wr_en = 1'b0; wr_be = 4'h0;
   endtask

   // Issue a fetch; optionally write into reg cw_addr during RD_A (capture edge of A).
   task automatic fetch(input int nops, input int aa, input int bb, input int cc, input bit hold,
                        input bit coll, input int cw_addr, input int cw_elem, input logic [31:0] cw_data);
      opnd_t rec;
      opnd_t got;
      int    n;
      int    k;
      bit    early_ready;
      n   = (nops == 0) ? 1 : nops;
      rec = exp_prev;
      rec.a = model[aa];
      if (n >= 2) rec.b = model[bb];
      if (n == 3) rec.c = model[cc];
      if (coll) begin
         model[cw_addr][cw_elem] = merge(model[cw_addr][cw_elem], cw_data, 4'hF);
`ifdef VRF_WR_BYPASS_EN
         if (cw_addr == aa) rec.a = model[aa];
`endif
      end
      sb.push_back(rec);
      exp_prev = rec;

      @(negedge clk);
      rd_valid = 1'b1; rd_nops = nops[1:0];
      a_addr = aa[4:0]; b_addr = bb[4:0]; c_addr = cc[4:0];
      @(negedge clk);
      if (!hold) rd_valid = 1'b0;
      a_addr = 5'd31; b_addr = 5'd31; c_addr = 5'd31; rd_nops = 2'd3;
      if (coll) begin
         wr_en = 1'b1; wr_addr = cw_addr[4:0]; wr_elem = cw_elem[1:0]; wdata = cw_data; wr_be = 4'hF;
      end
      early_ready = 1'b0;
      for (k = 1; k <= 12; k++) begin
         @(negedge clk);
         wr_en = 1'b0;
         if (rd_done) break;
         if (rd_ready) early_ready = 1'b1;
      end
      chk("done_latency", k, n);
      chk("ready_busy", {31'd0, early_ready}, 32'd0);
      chk("ready_at_done", {31'd0, rd_ready}, 32'd1);
      rd_valid = 1'b0;
      got = sb.pop_front();
      for (int l = 0; l < 4; l++) begin
         rd_elem = l[1:0];
         #1;
         chk($sformatf("a_lane%0d", l), a_rdata, got.a[l]);
         chk($sformatf("b_lane%0d", l), b_rdata, got.b[l]);
         chk($sformatf("c_lane%0d", l), c_rdata, got.c[l]);
      end
      @(negedge clk);
      chk("done_single", {31'd0, rd_done}, 32'd0);
      chk("idle_after", {31'd0, rd_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; rd_valid = 1'b0; rd_nops = 2'd0; a_addr = '0; b_addr = '0; c_addr = '0;
      rd_elem = '0; wr_en = 1'b0; wr_addr = '0; wr_elem = '0; wr_be = '0; wdata = '0; mask_en = 1'b1;
      for (int r = 0; r < 32; r++) model[r] = '0;
      exp_prev = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, rd_ready}, 32'd1);
      chk("rst_done", {31'd0, rd_done}, 32'd0);
      chk("rst_a", a_rdata, 32'd0);
      chk("rst_mask", mask_rdata, 32'd0);
      rst = 1'b0;

      // v3 lanes and single-operand fetch
      for (int l = 0; l < 4; l++) do_write(3, l, 32'h11 * (l + 1), 4'hF);
      fetch(1, 3, 0, 0, 1'b0, 1'b0, 0, 0, 32'h0);
      rd_elem = 2'd2; #1;
      chk("v3_lane2", a_rdata, 32'h33);

      // three-operand fetch with rd_valid held high
      for (int l = 0; l < 4; l++) begin
         do_write(1, l, 32'h1000 + l, 4'hF);
         do_write(2, l, (l == 0) ? 32'h11 : 32'h2000 + l, 4'hF);
         do_write(5, l, 32'h5000 + l, 4'hF);
      end
      fetch(3, 1, 2, 5, 1'b1, 1'b0, 0, 0, 32'h0);
      fetch(0, 5, 1, 2, 1'b0, 1'b0, 0, 0, 32'h0);
      fetch(2, 2, 3, 1, 1'b0, 1'b0, 0, 0, 32'h0);

      // byte enables
      do_write(4, 1, 32'hAABBCCDD, 4'hF);
      do_write(4, 1, 32'h11223344, 4'b0101);
      do_write(4, 2, 32'hDEADBEEF, 4'h0);
      fetch(1, 4, 0, 0, 1'b0, 1'b0, 0, 0, 32'h0);
      rd_elem = 2'd1; #1;
      chk("be_merge", a_rdata, 32'hAA22CC44);
      rd_elem = 2'd2; #1;
      chk("be_zero", a_rdata, 32'h0);

      // mask mirror
      do_write(0, 0, 32'hF0F0F0F0, 4'hF);
      mask_en = 1'b1; #1;
      chk("mask_on", mask_rdata, 32'hF0F0F0F0);
      mask_en = 1'b0; #1;
      chk("mask_off", mask_rdata, 32'h0);
      do_write(0, 1, 32'h12345678, 4'hF);
      mask_en = 1'b1; #1;
      chk("mask_lane1_nochg", mask_rdata, 32'hF0F0F0F0);

      // write/capture collision on v2 lane 0
      fetch(1, 2, 0, 0, 1'b0, 1'b1, 2, 0, 32'h55);
      rd_elem = 2'd0; #1;
`ifdef VRF_WR_BYPASS_EN
      chk("collision", a_rdata, 32'h55);
`else
      chk("collision", a_rdata, 32'h11);
`endif
      fetch(1, 2, 0, 0, 1'b0, 1'b0, 0, 0, 32'h0);
      rd_elem = 2'd0; #1;
      chk("collision_later", a_rdata, 32'h55);

      // reset in the middle of RD_B
      @(negedge clk);
      rd_valid = 1'b1; rd_nops = 2'd3; a_addr = 5'd1; b_addr = 5'd2; c_addr = 5'd5;
      @(negedge clk);
      rd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1; #1;
      chk("midrst_ready", {31'd0, rd_ready}, 32'd1);
      for (int l = 0; l < 4; l++) begin
         rd_elem = l[1:0]; #1;
         chk($sformatf("midrst_opnd%0d", l), a_rdata | b_rdata | c_rdata, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      begin
         bit saw_done;
         saw_done = 1'b0;
         repeat (6) begin
            @(negedge clk);
            if (rd_done) saw_done = 1'b1;
         end
         chk("midrst_no_done", {31'd0, saw_done}, 32'd0);
      end
      chk("sb_empty", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
